// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared constants for the EXE-stage multiply/divide unit.
//                These are the operation encodings, the FSM state encodings
//                and the default operand width.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  // Operation encoding. op[1] selects divide; op[0] selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_if
//  Description : Pipeline-side interface of the multiply/divide unit.
//  Ports       : master = pipeline (drives start/op/operands/flush/
//                hilo_rd/wr_hi/wr_lo/wr_data; reads hi/lo/busy/done/stall)
//                slave  = exe_muldiv (the reverse direction)
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH_DEF
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             hilo_rd;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, src_a, src_b, flush, hilo_rd, wr_hi, wr_lo, wr_data,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hilo_rd, wr_hi, wr_lo, wr_data,
    output hi, lo, busy, done, stall
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_divstep.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_divstep
//  Description : One combinational restoring-division step. The remainder
//                is shifted left with the next dividend bit, and the divisor
//                is subtracted when it fits.
//  Ports       : rem      in  WIDTH  current partial remainder (< divisor)
//                dvd_bit  in  1      next dividend bit (MSB first)
//                divisor  in  WIDTH  divisor
//                rem_next out WIDTH  next partial remainder
//                q_bit    out 1      quotient bit produced by this step
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted  = {rem, dvd_bit};
  assign q_bit    = (shifted >= {1'b0, divisor});
  // When the subtraction succeeds the true difference is below divisor,
  // so the low WIDTH bits of the wrapped difference are exact.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign rem_next = q_bit ? diff : shifted[WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/exe_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : exe_muldiv
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit that holds HI/LO.
//                The unit works on operand magnitudes for ITER cycles, and a
//                FIX cycle then applies signs and writes HI/LO. Stall
//                freezes upstream HI/LO users while the unit is busy.
//                Optional macro MULDIV_FAST_MUL_EN: multiplies complete in
//                one cycle (IDLE -> FIX); divides remain iterative.
//  Ports       : clk  in  clock (rising edge)
//                rst  in  asynchronous active-low reset
//                bus  slave modport of muldiv_if (see muldiv_if.sv)
//  Revision    : 1.0  initial release
// ============================================================================
module exe_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc;      // {remainder/upper, quotient/lower}
  logic [WIDTH-1:0]   b_mag;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw;    // raw dividend, kept for divide-by-zero
  logic               neg_q;    // operand signs differ (signed ops)
  logic [WIDTH-1:0]   hi_val;
  logic [WIDTH-1:0]   lo_val;
  logic               busy_q;
  logic               done_q;

  // ---- operand conditioning at issue ----
  logic             in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag_in, b_mag_in;

  assign in_signed = ~bus.op[0];
  assign a_neg     = in_signed & bus.src_a[WIDTH-1];
  assign b_neg     = in_signed & bus.src_b[WIDTH-1];
  assign a_mag_in  = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag_in  = b_neg ? -bus.src_b : bus.src_b;

  // ---- iteration datapath ----
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;

  // Shift-add: add the multiplicand to the upper half when the LSB is set,
  // then shift the whole accumulator right, carry included.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc[0] ? b_mag : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .dvd_bit  (acc[WIDTH-1]),
    .divisor  (b_mag),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );
  assign div_next = {rem_next, acc[WIDTH-2:0], q_bit};

  // ---- sign fixup / final result ----
  logic               q_signed;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign q_signed = ~op_q[0];
  assign prod_fix = (q_signed & neg_q) ? -acc : acc;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      if (b_mag == {WIDTH{1'b0}}) begin
        fix_lo = {WIDTH{1'b1}};
        fix_hi = a_raw;
      end else begin
        fix_lo = (q_signed & neg_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = (q_signed & a_raw[WIDTH-1]) ? -acc[2*WIDTH-1:WIDTH]
                                              : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_mag_in} * {{WIDTH{1'b0}}, b_mag_in};
`endif

  // ---- control ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_q   <= OP_MULT;
      acc    <= '0;
      b_mag  <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      hi_val <= '0;
      lo_val <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.wr_hi) hi_val <= bus.wr_data;
          if (bus.wr_lo) lo_val <= bus.wr_data;
          if (bus.start && !bus.flush) begin
            op_q   <= bus.op;
            a_raw  <= bus.src_a;
            b_mag  <= b_mag_in;
            neg_q  <= a_neg ^ b_neg;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            if (!bus.op[1]) begin
              acc   <= fast_prod;
              state <= ST_FIX;
            end else begin
              acc   <= {{WIDTH{1'b0}}, a_mag_in};
              state <= ST_CALC;
            end
`else
            acc   <= {{WIDTH{1'b0}}, a_mag_in};
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= op_q[1] ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(ITER - 1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          if (!bus.flush) begin
            hi_val <= fix_hi;
            lo_val <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi    = hi_val;
  assign bus.lo    = lo_val;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.start | bus.hilo_rd | bus.wr_hi | bus.wr_lo);

endmodule
`default_nettype wire

// File: doc/exe_muldiv.md
# exe_muldiv

Multi-cycle integer multiply/divide unit in the EXE stage. It consumes the operands and decoded mult/div operation that the ID/EXE pipeline register presents, and iterates for 32 cycles. It holds the architectural HI/LO registers and raises a combinational stall so that upstream stages freeze while HI/LO are not yet valid.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, WIDTH, number of iteration cycles per operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  the EXE-stage instruction is a mult/div; sampled only in IDLE.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs operand, after forwarding.
- src_b  in  WIDTH  rt operand, after forwarding.
- flush  in  1  aborts the in-flight operation.
- hilo_rd  in  1  the EXE-stage instruction is MFHI or MFLO.
- wr_hi  in  1  MTHI.
- wr_lo  in  1  MTLO.
- wr_data  in  WIDTH  data for MTHI/MTLO.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after HI/LO are updated by an operation.
- stall  out  1  combinational; equals busy & (start | hilo_rd | wr_hi | wr_lo).

## Operation
- States: IDLE, CALC, FIX.
- IDLE → CALC on start & !flush:
  - latch op.
  - latch the operand magnitudes; signed ops use abs().
  - latch the result sign flags.
  - cnt = 0.
- CALC:
  - MULT/MULTU: shift-add, one bit per cycle into a 2·WIDTH accumulator.
  - DIV/DIVU: restoring division, one quotient bit per cycle.
  - cnt increments; at cnt == ITER-1 go to FIX.
- FIX (signed ops only): negate the product if the operand signs differ.
- FIX (signed divide):
  - quotient is negative if the operand signs differ.
  - remainder takes the sign of the dividend.
- FIX: writes {hi, lo} (product: hi = upper half; divide: lo = quotient, hi = remainder), asserts done next cycle, then returns to IDLE.
- Divide by zero, signed or unsigned: lo = all-ones, hi = src_a as latched; sign fixup is skipped; latency is unchanged.
- Signed overflow 0x80000000 / −1: lo = 0x80000000, hi = 0.
- wr_hi/wr_lo with !busy: write wr_data at the edge. While busy they are stalled and not applied.
- start while busy: ignored; stall holds the instruction until IDLE.
- flush:
  - from any state, go to IDLE at the next edge; hi/lo unchanged; no done.
  - flush beats a simultaneous start.
- Reset (asynchronous, also mid-operation): state = IDLE, hi = lo = 0, busy = 0, done = 0, cnt = 0.

## Timing
- start sampled at edge E0.
- CALC occupies edges E1..E32.
- FIX → hi/lo update at E33; done is high in the cycle after E33.
- busy is high from just after E0 through E33.
- MFHI/MFLO issued in the cycle after E33 reads the new values with no stall.
- stall is purely combinational from busy and the request inputs; no registered delay.
- done and busy are registered and glitch-free.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full product with a single-cycle multiplier: IDLE → FIX directly, hi/lo updated at E1, done after E1.
  - DIV/DIVU are unchanged.
- Undefined: all operations use the iterative 34-edge path; no multiplier is inferred.

## Structure
- muldiv_pkg holds:
  - the op encoding localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - the state encoding (ST_IDLE, ST_CALC, ST_FIX).
  - the WIDTH default.
- One sub-module, muldiv_divstep: a combinational single restoring-division step. Inputs are the remainder, the dividend bit and the divisor; outputs are the next remainder and the quotient bit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001, done after E33, busy high 33 cycles.
- MULT −3 × 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. With MULDIV_FAST_MUL_EN: same result, done after E1.
- DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 / 0 → lo = 0xFFFFFFFF, hi = 0x00000064.
- hilo_rd held high from E1: stall = 1 until after E33, then 0 with the new lo visible. wr_lo during busy is not applied.
- flush at E10 of a DIVU 50 / 5 → IDLE at E11, hi/lo keep the prior values, no done. start with flush in the same cycle → stays IDLE.
- rst low mid-CALC (asynchronous, between edges) → busy, hi, lo and done go to 0 immediately. A fresh start after release completes normally.
